scalable_mac_engine: RTL and testbench
======================================

SCALABLE_MAC_ENGINE -- requirements
Module: scalable_mac_engine

Interface
REQ-001 Parameter ACT_W, default 8, signed activation width (>=4).
REQ-002 Parameter LANE_ACC_W, default 14, per-lane accumulator width (>= ACT_W+2); total result width RES_W = 4*LANE_ACC_W.
REQ-003 Parameter LEN_W, default 16, vector-length counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle job request, honoured only in IDLE.
REQ-007 prec_mode  in  2  00 full 8-bit weight, 01 dual 4-bit, 10 quad 2-bit, 11 reserved.
REQ-008 vec_len  in  LEN_W  number of operand pairs in the job, sampled with start.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand handshake; transfer when both high.
REQ-010 act / wgt  in / in  ACT_W / 8  signed activation / packed weight.
REQ-011 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 result  out  RES_W  packed accumulator(s); ovf  out  4  sticky per-lane saturation flags; busy  out  1  high when not IDLE.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start with vec_len>0 and prec_mode!=11; IDLE->DONE on start with vec_len==0; start with prec_mode==11 ignored.
REQ-014 On accepted start: latch prec_mode and vec_len, clear all accumulators, ovf and pair counter in the same edge.
REQ-015 in_ready = 1 only in RUN while accepted-count < latched vec_len; 0 in IDLE and DONE.
REQ-016 Each transfer registers the lane products at that edge (product stage); the accumulator adds them at the next edge; no bubbles at full throughput.
REQ-017 Mode 00: one lane, signed act x signed wgt[7:0], sign-extended into full RES_W accumulator.
REQ-018 Mode 01: lane L = act x signed wgt[3:0] in result[2*LANE_ACC_W-1:0]; lane H = act x signed wgt[7:4] in result[RES_W-1:2*LANE_ACC_W]; no carry between halves.
REQ-019 Mode 10: lane i (0..3) = act x signed wgt[2i+1:2i] in result[(i+1)*LANE_ACC_W-1:i*LANE_ACC_W]; no inter-lane carry.
REQ-020 Each accumulation saturates to the signed max/min of its lane width; saturation sets ovf bit of the lane's lowest quarter (mode 00 bit0; mode 01 bits 0,2; mode 10 bit i); ovf sticky until next accepted start.
REQ-021 RUN->DONE at the edge performing the final accumulation; out_valid visible after that edge (two edges after last operand acceptance edge).
REQ-022 DONE: out_valid=1, result/ovf stable; DONE->IDLE on out_ready; out_ready low holds indefinitely.
REQ-023 result and ovf hold their last values in IDLE until the next accepted start.
REQ-024 start, in_valid and prec_mode changes outside their legal windows have no effect.

Reset
REQ-025 rstn low at any time (including mid-RUN): state IDLE, result 0, ovf 0, product stage 0, counter 0, in_ready 0, out_valid 0, busy 0; in-flight job discarded.
REQ-026 First accepted start possible on first rising edge after rstn deasserts.

Structure
REQ-027 Shared package holds prec_mode encoding constants, FSM state typedef, and lane-count constant 4.
REQ-028 One sub-module prec_product_gen: combinational act x 8-bit weight generator producing four sign-extended 2-bit-slice partial products recombined per mode.
REQ-029 Saturating accumulator built per lane with a mode-controlled carry-chain break at lane boundaries.

Verification
REQ-030 Mode 00, vec_len=2, act=-3, wgt=0x7F twice -> result=-762 sign-extended, ovf=0, out_valid 2 edges after last transfer.
REQ-031 Mode 10, vec_len=1, act=5, wgt=0xE4 -> lanes 0..3 = 0, 5, -10, -5; ovf=0.
REQ-032 Mode 01, vec_len=3, act=-128, wgt=0x8F -> lane L=384, lane H=3072.
REQ-033 Mode 10, vec_len=65, act=127, wgt=0x55 (defaults) -> all lanes 8191, ovf=4'b1111.
REQ-034 rstn low mid-RUN after 3 of 10 transfers -> all outputs 0 immediately; fresh job then completes correctly.
REQ-035 vec_len=0 start -> out_valid next edge, result=0; out_ready low 5 cycles keeps out_valid high and result stable.

Source files
------------

// File: rtl/scalable_mac_engine_pkg.sv
// Shared definitions for the scalable MAC engine: precision-mode encodings,
// FSM state type, lane count and the lane-boundary helper.
package scalable_mac_engine_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] PREC_FULL = 2'b00;
  localparam logic [1:0] PREC_DUAL = 2'b01;
  localparam logic [1:0] PREC_QUAD = 2'b10;
  localparam logic [1:0] PREC_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // True when accumulator quarter q is the lowest quarter of a logical lane,
  // i.e. where the carry chain is broken for the given precision mode.
  function automatic logic lane_break(input logic [1:0] mode, input int q);
    case (mode)
      PREC_DUAL: return (q == 0) || (q == 2);
      PREC_QUAD: return 1'b1;
      default:   return (q == 0);
    endcase
  endfunction

endpackage

// File: rtl/scalable_mac_engine_prec_product_gen.sv
// Combinational act x packed-weight generator: four 2-bit-slice partial
// products recombined into one, two or four lane products per mode.
module prec_product_gen
  import scalable_mac_engine_pkg::*;
#(
  parameter int ACT_W  = 8,
  parameter int PROD_W = ACT_W + 8
) (
  input  logic [ACT_W-1:0]            act,
  input  logic [7:0]                  wgt,
  input  logic [1:0]                  mode,
  output logic [NUM_LANES*PROD_W-1:0] prod
);

  logic signed [2:0]        sl;
  logic signed [ACT_W+2:0]  pp  [NUM_LANES];
  logic signed [PROD_W-1:0] ext [NUM_LANES];
  logic signed [PROD_W-1:0] full, lo, hi;
  logic                     slice_signed;

  always_comb begin
    // NOTE: every always_comb target gets a default before any branch; a path
    // that leaves one unassigned makes synthesis infer a latch.
    prod         = '0;
    sl           = '0;
    slice_signed = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      // A slice is signed only when it is the most significant slice of its lane.
      slice_signed = (i == NUM_LANES - 1) || (mode == PREC_QUAD) ||
                     ((mode == PREC_DUAL) && (i == 1));
      sl     = {slice_signed & wgt[2*i+1], wgt[2*i+1 -: 2]};
      pp[i]  = (ACT_W+3)'($signed(act)) * (ACT_W+3)'(sl);
      ext[i] = PROD_W'(pp[i]);
    end

    full = (ext[3] <<< 6) + (ext[2] <<< 4) + (ext[1] <<< 2) + ext[0];
    lo   = (ext[1] <<< 2) + ext[0];
    hi   = (ext[3] <<< 2) + ext[2];

    case (mode)
      PREC_FULL: prod[0 +: PROD_W] = full;
      PREC_DUAL: begin
        prod[0 +: PROD_W]        = lo;
        prod[2*PROD_W +: PROD_W] = hi;
      end
      PREC_QUAD: begin
        for (int i = 0; i < NUM_LANES; i++) prod[i*PROD_W +: PROD_W] = ext[i];
      end
      default: prod = '0;
    endcase
  end

endmodule

// File: rtl/scalable_mac_engine.sv
// Multi-precision multiply-accumulate engine: a job of vec_len operand pairs is
// accumulated into 1, 2 or 4 saturating lanes, then held until acknowledged.
module scalable_mac_engine
  import scalable_mac_engine_pkg::*;
#(
  parameter int ACT_W      = 8,
  parameter int LANE_ACC_W = 14,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              prec_mode,
  input  logic [LEN_W-1:0]        vec_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACT_W-1:0]        act,
  input  logic [7:0]              wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*LANE_ACC_W-1:0] result,
  output logic [3:0]              ovf,
  output logic                    busy
);

  localparam int Q      = LANE_ACC_W;
  localparam int RES_W  = NUM_LANES * Q;
  localparam int PROD_W = ACT_W + 8;

  state_t                     state, state_nxt;
  logic [1:0]                 mode_q;
  logic [LEN_W-1:0]           len_q, cnt_q;
  logic [NUM_LANES*PROD_W-1:0] prod, prod_q;
  logic                       prod_vld_q;
  logic [RES_W-1:0]           acc_q, acc_nxt, addend, sum;
  logic [3:0]                 ovf_q, ovf_nxt, sat, sat_neg;
  logic                       start_ok, fire, last_acc;

  logic signed [PROD_W-1:0]   p [NUM_LANES];
  logic [Q:0]                 seg;
  logic                       carry, a_s, is_top;
  logic [1:0]                 base;

  assign start_ok  = (state == ST_IDLE) && start && (prec_mode != PREC_RSVD);
  assign in_ready  = (state == ST_RUN) && (cnt_q < len_q);
  assign fire      = in_valid && in_ready;
  assign last_acc  = (state == ST_RUN) && prod_vld_q && (cnt_q == len_q);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign result    = acc_q;
  assign ovf       = ovf_q;

  prec_product_gen #(.ACT_W(ACT_W), .PROD_W(PROD_W)) u_prod (
    .act  (act),
    .wgt  (wgt),
    .mode (mode_q),
    .prod (prod)
  );

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = (vec_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_acc) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Lane-aligned addend, quarter-wise carry chain broken at lane boundaries,
  // then per-lane saturation with the ovf flag kept at the lane's lowest quarter.
  always_comb begin
    addend  = '0;
    sum     = '0;
    sat     = '0;
    sat_neg = '0;
    seg     = '0;
    carry   = 1'b0;
    a_s     = 1'b0;
    is_top  = 1'b0;
    base    = '0;
    for (int i = 0; i < NUM_LANES; i++) p[i] = $signed(prod_q[i*PROD_W +: PROD_W]);

    case (mode_q)
      PREC_FULL: addend = RES_W'(p[0]);
      PREC_DUAL: addend = {(2*Q)'(p[2]), (2*Q)'(p[0])};
      PREC_QUAD: addend = {Q'(p[3]), Q'(p[2]), Q'(p[1]), Q'(p[0])};
      default:   addend = '0;
    endcase

    for (int q = 0; q < NUM_LANES; q++) begin
      if (lane_break(mode_q, q)) begin
        carry = 1'b0;
        base  = 2'(q);
      end
      seg   = {1'b0, acc_q[q*Q +: Q]} + {1'b0, addend[q*Q +: Q]} + {{Q{1'b0}}, carry};
      sum[q*Q +: Q] = seg[Q-1:0];
      carry = seg[Q];
      is_top = (q == NUM_LANES - 1) || lane_break(mode_q, q + 1);
      if (is_top) begin
        a_s = acc_q[(q+1)*Q-1];
        if ((a_s == addend[(q+1)*Q-1]) && (sum[(q+1)*Q-1] != a_s)) begin
          sat[base]     = 1'b1;
          sat_neg[base] = addend[(q+1)*Q-1];
        end
      end
    end

    acc_nxt = sum;
    for (int q = 0; q < NUM_LANES; q++) begin
      if (lane_break(mode_q, q)) base = 2'(q);
      is_top = (q == NUM_LANES - 1) || lane_break(mode_q, q + 1);
      if (sat[base]) begin
        acc_nxt[q*Q +: Q] = is_top ? {sat_neg[base], {(Q-1){~sat_neg[base]}}}
                                   : {Q{~sat_neg[base]}};
      end
    end
    ovf_nxt = ovf_q | sat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q     <= PREC_FULL;
      len_q      <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= '0;
    end else if (start_ok) begin
      mode_q     <= prec_mode;
      len_q      <= vec_len;
      cnt_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= '0;
    end else begin
      prod_vld_q <= fire;
      if (fire) begin
        cnt_q  <= cnt_q + 1'b1;
        prod_q <= prod;
      end
      if (prod_vld_q) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_scalable_mac_engine.sv
// Scoreboard bench for scalable_mac_engine: the driver queues hand-computed
// results per job, a negedge monitor compares whenever out_valid is presented.
module tb_scalable_mac_engine;

  localparam int Q     = 14;
  localparam int RES_W = 4 * Q;

  logic             clk, rstn, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]       prec_mode;
  logic [15:0]      vec_len;
  logic [7:0]       act, wgt;
  logic [RES_W-1:0] result;
  logic [3:0]       ovf;

  typedef struct {
    logic [RES_W-1:0] res;
    logic [3:0]       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  scalable_mac_engine dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .prec_mode (prec_mode),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [RES_W-1:0] quad(input int l3, input int l2, input int l1, input int l0);
    return {14'(l3), 14'(l2), 14'(l1), 14'(l0)};
  endfunction

  function automatic logic [RES_W-1:0] dual(input int h, input int l);
    return {28'(h), 28'(l)};
  endfunction

  // Monitor: every presented result must match the head of the scoreboard,
  // including each held cycle; the entry retires on the accepting cycle.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("result", 64'(result), 64'(exp_q[0].res));
        check("ovf", 64'(ovf), 64'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] w);
    int guard = 0;
    act      = a;
    wgt      = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    check("in_ready_seen", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [1:0] mode, input int len, input logic [7:0] a,
                         input logic [7:0] w, input logic [RES_W-1:0] er,
                         input logic [3:0] eo, input bit noisy, input int hold);
    int guard = 0;
    exp_q.push_back('{res: er, ovf: eo});
    prec_mode = mode;
    vec_len   = 16'(len);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = noisy;
    prec_mode = 2'b11;
    vec_len   = 16'hFFFF;
    for (int i = 0; i < len; i++) send(a, w);
    start    = 1'b0;
    in_valid = 1'b0;
    if (len > 0) begin
      @(negedge clk);
      check("no_early_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("valid_latency", 64'(out_valid), 64'd1);
    while (!out_valid && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check("valid_timeout", 64'(out_valid), 64'd1);
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_ack", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prec_mode = 2'b00;
    vec_len   = '0;
    act       = '0;
    wgt       = '0;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rstn = 1'b1;

    // Job started on the very first edge after reset release.
    run_job(2'b00, 2, 8'hFD, 8'h7F, RES_W'(-762), 4'b0000, 1'b0, 0);
    run_job(2'b10, 1, 8'h05, 8'hE4, quad(-5, -10, 5, 0), 4'b0000, 1'b0, 0);
    run_job(2'b01, 3, 8'h80, 8'h8F, dual(3072, 384), 4'b0000, 1'b1, 0);
    run_job(2'b10, 65, 8'h7F, 8'h55, quad(8191, 8191, 8191, 8191), 4'b1111, 1'b0, 0);
    run_job(2'b10, 33, 8'h7F, 8'h9A, quad(-8192, 4191, -8192, -8192), 4'b1011, 1'b0, 0);
    check("idle_hold_result", 64'(result), 64'(quad(-8192, 4191, -8192, -8192)));
    check("idle_hold_ovf", 64'(ovf), 64'd11);

    // Reserved precision mode: start must be ignored.
    prec_mode = 2'b11;
    vec_len   = 16'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_in_ready", 64'(in_ready), 64'd0);
    check("rsvd_result_kept", 64'(result), 64'(quad(-8192, 4191, -8192, -8192)));

    run_job(2'b00, 0, 8'h00, 8'h00, '0, 4'b0000, 1'b0, 5);

    // Reset in the middle of a 10-pair job after 3 transfers.
    prec_mode = 2'b10;
    vec_len   = 16'd10;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h05, 8'h55);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_run_busy", 64'(busy), 64'd1);
    check("mid_run_result", 64'(result), 64'(quad(15, 15, 15, 15)));
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_job(2'b01, 2, 8'h07, 8'h2F, dual(28, -14), 4'b0000, 1'b0, 0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
